mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Target-side end of the byte-serial CPU memory bus driven by the CPU handler. Tracks the same
//  10-slot frame, captures a 32-bit address and write word from the two 8-bit lanes, decodes the
//  write flag, and returns a 32-bit read word over the bidirectional lane.
//  Backed by an internal word-addressed register memory.
//  Sits outside the CPU handler, used as bench/FPGA companion and as the reference memory model.
// PARAMETERS
//  DEPTH     16  number of 32-bit words in memory (power of 2, 2..256)
//  INIT_VAL  0   reset value of every memory word
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  a_in       in   8  address/control lane (handler uo_out)
//  d_in       in   8  data lane, host->target (handler uio_out)
//  d_out      out  8  data lane, target->host (handler uio_in)
//  d_oe       out  1  1 = responder drives d_out onto the data lane
//  wr_strobe  out  1  1-cycle pulse, memory write committed this edge
//  oor        out  1  sticky: an out-of-range address was seen; cleared only by reset
//  frame_end  out  1  1-cycle pulse in slot 9
// BEHAVIOUR
//  Reset: slot=0, addr/wdata/wr_flag=0, memory=INIT_VAL, d_out=0, d_oe=0, wr_strobe=0, oor=0.
//  Slot counter: 0,1,...,9,0,... free-running from reset release; both ends leave reset together.
//  Host registers its outputs, so host byte k (k=0..3) is sampled by the target one slot late.
//  Slot 0,1: idle; nothing captured, d_oe=0.
//  Slot 2..5: capture addr[8(s-2)+:8] <= a_in and wdata[8(s-2)+:8] <= d_in at end of slot s.
//  Slot 6: a_in[0] is the write flag (1=write, 1-bit field; a_in[7:1] ignored).
//    If a_in[0]=1 at end of slot 6 and address in range: mem[idx] <= wdata, wr_strobe=1 that cycle.
//    wr_flag <= a_in[0], held through slot 9.
//  Read return: rdata = mem[idx] as of the start of slot 6 (read-before-write in the same frame).
//    d_out is combinational from slot and rdata: slot6 byte0, slot7 byte1, slot8 byte2, slot9 byte3.
//    d_oe = 1 in slot 6 iff a_in[0]=0, in slots 7..9 iff wr_flag=0; otherwise d_oe=0 and d_out=0.
//  Address decode: idx = addr[2 +: log2(DEPTH)]; addr[1:0] ignored.
//    In range iff addr[31:2+log2(DEPTH)]==0. Out of range: rdata=0, write dropped (no wr_strobe),
//    oor set at end of slot 6.
//  Bytes are captured as they appear on the lanes; the responder does not check byte duplication.
//  frame_end=1 during slot 9. Slot 9 is followed by slot 0; addr and wdata are kept until overwritten.
//  Async reset mid-frame: immediate return to the reset state; any uncommitted write is lost.
// STRUCTURE
//  Shared package: SLOT_W=4, slot constants SLOT_IDLE0, SLOT_A0..SLOT_A3 (2..5), SLOT_RW (6),
//  SLOT_R0..SLOT_R3 (6..9), SLOT_LAST (9), FRAME_LEN=10, WR_FLAG_BIT=0. The CPU handler shares
//  these same constants.
//  Sub-module bus_slot_counter: mod-FRAME_LEN counter with async reset and frame_end output.
//  Memory array, capture registers and lane mux sit in the top module.
// TESTING
//  1. Reset, idle lanes for 2 frames -> d_oe pulses only in slots 6..9, d_out=INIT_VAL bytes,
//     no wr_strobe, oor=0.
//  2. Write frame addr=0x0000_0008, wdata=0xDEADBEEF, flag=1 -> wr_strobe in slot 6, d_oe=0 in 6..9;
//     mem[2]=0xDEADBEEF.
//  3. Read frame addr=0x0000_0008, flag=0 -> d_out EF,BE,AD,DE in slots 6..9, d_oe=1.
//  4. Write to addr=0x0000_0040 (DEPTH=16) -> no wr_strobe, oor=1 and sticky;
//     next read there -> d_out=00 x4.
//  5. Write 0x11223344 then same-frame readback on addr 0x4 -> read returns old word only if flag=0;
//     next read frame returns 0x11223344.
//  6. Assert rst_n low in slot 4 of a write frame -> all outputs 0 immediately; memory unchanged
//     from INIT_VAL; slot restarts at 0.

Source files
------------

// File: rtl/mem_bus_responder_pkg.sv
// Shared frame constants for the byte-serial CPU memory bus.
// The CPU handler imports the same package, so both ends agree on slot numbering.
package mem_bus_responder_pkg;

  localparam int SLOT_W    = 4;
  localparam int FRAME_LEN = 10;

  typedef logic [SLOT_W-1:0] slot_t;

  // slot | meaning
  // 0,1  | idle, nothing captured
  // 2..5 | address / write-data byte 0..3 sampled at end of slot
  // 6    | write flag on a_in[0]; read byte 0 returned
  // 7..9 | read bytes 1..3 returned; 9 is the last slot of the frame
  localparam slot_t SLOT_IDLE0 = slot_t'(0);
  localparam slot_t SLOT_IDLE1 = slot_t'(1);
  localparam slot_t SLOT_A0    = slot_t'(2);
  localparam slot_t SLOT_A1    = slot_t'(3);
  localparam slot_t SLOT_A2    = slot_t'(4);
  localparam slot_t SLOT_A3    = slot_t'(5);
  localparam slot_t SLOT_RW    = slot_t'(6);
  localparam slot_t SLOT_R0    = slot_t'(6);
  localparam slot_t SLOT_R1    = slot_t'(7);
  localparam slot_t SLOT_R2    = slot_t'(8);
  localparam slot_t SLOT_R3    = slot_t'(9);
  localparam slot_t SLOT_LAST  = slot_t'(FRAME_LEN - 1);

  localparam int WR_FLAG_BIT = 0;

endpackage

// File: rtl/bus_slot_counter.sv
// Free-running mod-FRAME_LEN slot counter shared in lockstep with the CPU handler.
module bus_slot_counter
  import mem_bus_responder_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  output slot_t slot,
  output logic  frame_end
);

  // Advance one slot per clock, wrapping after the last slot of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_IDLE0;
    end else if (slot == SLOT_LAST) begin
      slot <= SLOT_IDLE0;
    end else begin
      slot <= slot + slot_t'(1);
    end
  end

  // Last-slot marker.
  always_comb begin
    frame_end = (slot == SLOT_LAST);
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Target-side responder for the byte-serial CPU memory bus, backed by a
// word-addressed register memory. Captures address and write word over slots
// 2..5, commits or reads in slot 6, and returns the read word over slots 6..9.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       wr_strobe,
  output logic       oor,
  output logic       frame_end
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int IDX_HI = 2 + IDX_W;

  slot_t             slot;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              wr_flag;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_now;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              wr_en;
  logic [31:0]       mem [DEPTH];

  bus_slot_counter u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot      (slot),
    .frame_end (frame_end)
  );

  // Address decode; out-of-range words read as zero and are never written.
  always_comb begin
    idx       = addr[2 +: IDX_W];
    in_range  = (addr[31:IDX_HI] == '0);
    rdata_now = in_range ? mem[idx] : '0;
    wr_en     = (slot == SLOT_RW) && a_in[WR_FLAG_BIT] && in_range;
    wr_strobe = wr_en;
  end

  // Lane capture, write-flag latch, read-word snapshot and sticky range error.
  // rdata_q freezes the pre-write word so slots 7..9 still return the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      wdata   <= '0;
      wr_flag <= 1'b0;
      rdata_q <= '0;
      oor     <= 1'b0;
    end else begin
      case (slot)
        SLOT_A0: begin addr[7:0]   <= a_in; wdata[7:0]   <= d_in; end
        SLOT_A1: begin addr[15:8]  <= a_in; wdata[15:8]  <= d_in; end
        SLOT_A2: begin addr[23:16] <= a_in; wdata[23:16] <= d_in; end
        SLOT_A3: begin addr[31:24] <= a_in; wdata[31:24] <= d_in; end
        SLOT_RW: begin
          wr_flag <= a_in[WR_FLAG_BIT];
          rdata_q <= rdata_now;
          if (!in_range) oor <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register memory; a reset mid-frame discards any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  // Return-lane mux: byte 0 straight from memory in slot 6, bytes 1..3 from the snapshot.
  always_comb begin
    d_out = '0;
    d_oe  = 1'b0;
    case (slot)
      SLOT_R0: if (!a_in[WR_FLAG_BIT]) begin d_oe = 1'b1; d_out = rdata_now[7:0];  end
      SLOT_R1: if (!wr_flag)           begin d_oe = 1'b1; d_out = rdata_q[15:8];   end
      SLOT_R2: if (!wr_flag)           begin d_oe = 1'b1; d_out = rdata_q[23:16];  end
      SLOT_R3: if (!wr_flag)           begin d_oe = 1'b1; d_out = rdata_q[31:24];  end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (DEPTH=16, INIT_VAL=0).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_mem_bus_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       wr_strobe;
  logic       oor;
  logic       frame_end;

  int n_assert;
  int n_fail;

  logic [31:0] model_mem [16];
  logic        oor_exp;

  mem_bus_responder #(.DEPTH(16), .INIT_VAL(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .d_in      (d_in),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .wr_strobe (wr_strobe),
    .oor       (oor),
    .frame_end (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    oor_exp = 1'b0;
  endtask

  // Run slots 0..n_slots-1 of a frame; entry and exit are 1 unit after a rising edge.
  task automatic run_frame(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic flag, input int n_slots);
    logic        inr;
    logic [3:0]  ix;
    logic [31:0] exp_rd;
    logic        exp_oe;
    logic [7:0]  exp_d;
    inr    = (addr[31:6] == 26'h0);
    ix     = addr[5:2];
    exp_rd = inr ? model_mem[ix] : 32'h0;
    for (int s = 0; s < n_slots; s++) begin
      a_in = 8'h00;
      d_in = 8'h00;
      if (s >= 2 && s <= 5) begin
        a_in = addr[8*(s-2) +: 8];
        d_in = wdata[8*(s-2) +: 8];
      end else if (s == 6) begin
        a_in = {7'b0, flag};
      end
      @(negedge clk);
      exp_oe = (s >= 6) && !flag;
      exp_d  = exp_oe ? exp_rd[8*(s-6) +: 8] : 8'h00;
      chk($sformatf("d_oe a=%h s=%0d", addr, s), {31'b0, d_oe}, {31'b0, exp_oe});
      chk($sformatf("d_out a=%h s=%0d", addr, s), {24'b0, d_out}, {24'b0, exp_d});
      chk($sformatf("wr_strobe a=%h s=%0d", addr, s), {31'b0, wr_strobe},
          {31'b0, (s == 6) && flag && inr});
      chk($sformatf("frame_end s=%0d", s), {31'b0, frame_end}, {31'b0, s == 9});
      chk($sformatf("oor a=%h s=%0d", addr, s), {31'b0, oor}, {31'b0, oor_exp});
      @(posedge clk);
      #1;
      if (s == 6) begin
        if (!inr) oor_exp = 1'b1;
        if (flag && inr) model_mem[ix] = wdata;
      end
    end
    a_in = 8'h00;
    d_in = 8'h00;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a_in     = 8'h00;
    d_in     = 8'h00;
    model_reset();

    #2;
    chk("reset d_oe", {31'b0, d_oe}, 32'h0);
    chk("reset d_out", {24'b0, d_out}, 32'h0);
    chk("reset wr_strobe", {31'b0, wr_strobe}, 32'h0);
    chk("reset oor", {31'b0, oor}, 32'h0);
    chk("reset frame_end", {31'b0, frame_end}, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle lanes: reads of word 0 returning INIT_VAL
    run_frame(32'h0000_0000, 32'h0, 1'b0, 10);
    run_frame(32'h0000_0000, 32'h0, 1'b0, 10);

    // Write then read word 2, also via an unaligned byte address
    run_frame(32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 10);
    chk("model mem[2]", model_mem[2], 32'hDEAD_BEEF);
    run_frame(32'h0000_0008, 32'h0, 1'b0, 10);
    run_frame(32'h0000_000B, 32'h0, 1'b0, 10);

    // Top in-range word and first out-of-range address
    run_frame(32'h0000_003C, 32'h55AA_00FF, 1'b1, 10);
    run_frame(32'h0000_003C, 32'h0, 1'b0, 10);
    run_frame(32'h0000_0040, 32'hCAFE_F00D, 1'b1, 10);
    chk("oor after bad write", {31'b0, oor}, 32'h1);
    run_frame(32'h0000_0040, 32'h0, 1'b0, 10);
    run_frame(32'h8000_0000, 32'h0, 1'b0, 10);
    run_frame(32'h0000_0000, 32'h0, 1'b0, 10);
    chk("oor sticky", {31'b0, oor}, 32'h1);

    // Word 1: old value, overwrite, new value
    run_frame(32'h0000_0004, 32'h0, 1'b0, 10);
    run_frame(32'h0000_0004, 32'h1122_3344, 1'b1, 10);
    run_frame(32'h0000_0004, 32'h0, 1'b0, 10);

    // Reset in slot 4 of a write frame
    run_frame(32'h0000_0008, 32'h1234_5678, 1'b1, 4);
    a_in = 8'h00;
    d_in = 8'h56;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset d_oe", {31'b0, d_oe}, 32'h0);
    chk("midreset d_out", {24'b0, d_out}, 32'h0);
    chk("midreset wr_strobe", {31'b0, wr_strobe}, 32'h0);
    chk("midreset oor", {31'b0, oor}, 32'h0);
    chk("midreset frame_end", {31'b0, frame_end}, 32'h0);
    model_reset();
    d_in = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(32'h0000_0008, 32'h0, 1'b0, 10);
    run_frame(32'h0000_0004, 32'h0, 1'b0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
